bcd_updown_counter: RTL and testbench
=====================================

// Module: bcd_updown_counter
// PURPOSE
//   Parametrised N-digit BCD up/down counter for the counter/display path.
//   Generalises the fixed 3-digit up-only BCD counter: digit count is
//   configurable, direction is selectable, and it adds parallel load,
//   synchronous clear and a wrap/saturate mode. It advances one step per
//   qualified cin pulse and drives a decimal display or cascade stage via q/cout.
// PARAMETERS
//   DIGITS  3  number of BCD digits (1..8); q width = 4*DIGITS
//   WRAP    1  1: wrap at the limits (999->000, 000->999); 0: saturate at the limits
// PORTS
//   clk       in   1         system clock, rising edge
//   rst       in   1         asynchronous reset, active-high
//   cin       in   1         count enable; one step per cycle it is high
//   up_dn     in   1         1 = count up, 0 = count down (sampled with cin)
//   clr       in   1         synchronous clear to zero
//   load      in   1         synchronous parallel load of load_val
//   load_val  in   4*DIGITS  BCD load value, digit 0 in [3:0]
//   q         out  4*DIGITS  current BCD count, digit 0 = least significant
//   cout      out  1         registered carry/borrow pulse, 1 cycle
//   load_err  out  1         registered pulse: load rejected, invalid BCD digit
// BEHAVIOUR
//   - Reset (rst=1, asynchronous): q=0, cout=0, load_err=0; all are held while rst=1.
//   - Priority per rising edge: clr > load > cin. Lower-priority inputs in the
//     same cycle are ignored (no count, no cout).
//   - clr: q<=0 on the next edge; cout=0, load_err=0.
//   - load: if every nibble of load_val is <=9, q<=load_val. If any nibble
//     is >9, q holds and load_err=1 for exactly one cycle. cout=0 in both cases.
//   - Count (cin=1, no clr/load), up_dn=1: digit0 increments. Digit k
//     increments only if digits 0..k-1 are all 9; a digit at 9 that
//     increments becomes 0. Counting down mirrors this: digit k decrements only
//     if digits 0..k-1 are all 0, and a digit at 0 that decrements becomes 9.
//   - Upper limit, all digits 9, counting up: with WRAP=1, q<=0 and cout=1.
//     With WRAP=0, q holds at all-9s and cout=1 (overflow attempt).
//   - Lower limit, all digits 0, counting down: with WRAP=1, q<=all-9s and
//     cout=1 (borrow). With WRAP=0, q holds at 0 and cout=1.
//   - Latency: q and cout update on the same edge that samples cin (1 cycle).
//     cout is high only in the cycle after a limit event and is 0 otherwise;
//     when cin is held high it re-asserts once per limit crossing.
//   - q never holds a non-BCD nibble: it is not reachable by counting, and
//     load blocks it.
//   - up_dn can change in any cycle; the value sampled with cin takes effect.
//   - rst asserted mid-count: q, cout and load_err clear immediately. The
//     first count after rst deasserts starts from 0.
// TESTING (DIGITS=3 unless noted)
//   1 rst=1 for 10 cycles, then release; cin pulses 1 in 6 cycles, 1000 pulses,
//     up -> q walks 000..999 then 000; cout=1 once, on the 999->000 edge.
//   2 load 12'h099, one up pulse -> q=12'h100 (multi-digit carry), cout=0;
//     load 12'h100, one down pulse -> q=12'h099, cout=0.
//   3 load 12'h000, down pulse -> WRAP=1: q=12'h999, cout=1;
//     WRAP=0 build: q stays 12'h000, cout=1.
//   4 load 12'h9A3 -> q unchanged, load_err=1 for one cycle;
//     then load 12'h123 -> q=12'h123, load_err=0.
//   5 clr, load and cin all high in one cycle -> q=0, no cout;
//     load and cin high together -> q=load_val, no increment.
//   6 rst pulse asserted mid-cycle during continuous cin -> q=0 before the next
//     edge; DIGITS=1 build, up from 9 -> q=0, cout=1.

Source files
------------

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// bcd_updown_counter : N-digit BCD up/down counter with load, clear, wrap/sat
// Revision: 1.0
// ============================================================================
module bcd_updown_counter #(
  parameter int DIGITS = 3,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cin,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  cout,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      r_q;
  logic              r_cout;
  logic              r_load_err;

  logic [W-1:0]      w_next;
  logic [DIGITS:0]   w_chain9;
  logic [DIGITS:0]   w_chain0;
  logic [DIGITS-1:0] w_nib_ok;
  logic              w_load_ok;
  logic              w_limit;

  assign w_chain9[0] = 1'b1;
  assign w_chain0[0] = 1'b1;

  // Digit k moves only when every lower digit sits at its roll-over value.
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      logic [3:0] w_dig;
      logic [3:0] w_up;
      logic [3:0] w_dn;
      assign w_dig         = r_q[4*k +: 4];
      assign w_chain9[k+1] = w_chain9[k] & (w_dig == 4'd9);
      assign w_chain0[k+1] = w_chain0[k] & (w_dig == 4'd0);
      assign w_up          = (w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1;
      assign w_dn          = (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
      assign w_next[4*k +: 4] = up_dn ? (w_chain9[k] ? w_up : w_dig)
                                      : (w_chain0[k] ? w_dn : w_dig);
      assign w_nib_ok[k]   = (load_val[4*k +: 4] <= 4'd9);
    end : g_digit
  endgenerate

  assign w_load_ok = &w_nib_ok;
  assign w_limit   = up_dn ? w_chain9[DIGITS] : w_chain0[DIGITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q        <= '0;
      r_cout     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_cout     <= 1'b0;
      r_load_err <= 1'b0;
      if (clr) begin
        r_q <= '0;
      end else if (load) begin
        if (w_load_ok) begin
          r_q <= load_val;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (cin) begin
        // Saturating build holds at the limit but still flags the attempt.
        if (!(w_limit && !WRAP)) begin
          r_q <= w_next;
        end
        r_cout <= w_limit;
      end
    end
  end

  assign q        = r_q;
  assign cout     = r_cout;
  assign load_err = r_load_err;

endmodule : bcd_updown_counter
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// tb_bcd_updown_counter : directed self-checking bench for bcd_updown_counter
// Revision: 1.0
// ============================================================================
module tb_bcd_updown_counter;

  logic        clk;
  logic        rst;
  logic        cin;
  logic        up_dn;
  logic        clr;
  logic        load;
  logic [11:0] load_val;
  logic [11:0] q;
  logic        cout;
  logic        load_err;
  logic [11:0] q_sat;
  logic        cout_sat;
  logic        load_err_sat;
  logic [3:0]  q1;
  logic        cout1;
  logic        load_err1;

  int n_vec = 0;
  int n_err = 0;

  bcd_updown_counter #(.DIGITS(3), .WRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .cin(cin), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .q(q), .cout(cout), .load_err(load_err)
  );

  bcd_updown_counter #(.DIGITS(3), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .cin(cin), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .q(q_sat), .cout(cout_sat), .load_err(load_err_sat)
  );

  bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cin(cin), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .q(q1), .cout(cout1), .load_err(load_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    to_bcd = {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic do_load(input logic [11:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse(input logic dir);
    cin = 1'b1; up_dn = dir;
    tick();
    cin = 1'b0;
  endtask

  int extra_cout;

  initial begin
    rst = 1'b1; cin = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    repeat (10) tick();
    chk("rst_q", 16'(q), 16'h000);
    chk("rst_cout", 16'(cout), 16'h0);
    chk("rst_err", 16'(load_err), 16'h0);
    rst = 1'b0;

    // Full up walk 000..999..000 with sparse cin
    extra_cout = 0;
    for (int i = 1; i <= 1000; i++) begin
      pulse(1'b1);
      chk("walk_q", 16'(q), 16'(to_bcd(i % 1000)));
      chk("walk_cout", 16'(cout), (i == 1000) ? 16'h1 : 16'h0);
      for (int j = 0; j < 5; j++) begin
        tick();
        if (cout) extra_cout++;
      end
    end
    chk("walk_extra_cout", 16'(extra_cout), 16'h0);
    chk("sat_hold_999", 16'(q_sat), 16'h999);

    // Multi-digit carry and borrow
    do_load(12'h099);
    pulse(1'b1);
    chk("carry_q", 16'(q), 16'h100);
    chk("carry_cout", 16'(cout), 16'h0);
    do_load(12'h100);
    pulse(1'b0);
    chk("borrow_q", 16'(q), 16'h099);
    chk("borrow_cout", 16'(cout), 16'h0);

    // Lower limit: wrap vs saturate
    do_load(12'h000);
    pulse(1'b0);
    chk("wrap_dn_q", 16'(q), 16'h999);
    chk("wrap_dn_cout", 16'(cout), 16'h1);
    chk("sat_dn_q", 16'(q_sat), 16'h000);
    chk("sat_dn_cout", 16'(cout_sat), 16'h1);
    tick();
    chk("cout_one_cycle", 16'(cout), 16'h0);

    // Upper limit on saturating build
    do_load(12'h999);
    pulse(1'b1);
    chk("sat_up_q", 16'(q_sat), 16'h999);
    chk("sat_up_cout", 16'(cout_sat), 16'h1);
    chk("wrap_up_q", 16'(q), 16'h000);

    // Invalid load rejected
    do_load(12'h123);
    do_load(12'h9A3);
    chk("bad_load_q", 16'(q), 16'h123);
    chk("bad_load_err", 16'(load_err), 16'h1);
    tick();
    chk("bad_load_err_drop", 16'(load_err), 16'h0);
    do_load(12'h456);
    chk("good_load_q", 16'(q), 16'h456);
    chk("good_load_err", 16'(load_err), 16'h0);

    // Priority
    clr = 1'b1; load = 1'b1; cin = 1'b1; up_dn = 1'b1; load_val = 12'h777;
    tick();
    clr = 1'b0; load = 1'b0; cin = 1'b0;
    chk("prio_clr_q", 16'(q), 16'h000);
    chk("prio_clr_cout", 16'(cout), 16'h0);
    load = 1'b1; cin = 1'b1; load_val = 12'h999;
    tick();
    load = 1'b0; cin = 1'b0;
    chk("prio_load_q", 16'(q), 16'h999);
    chk("prio_load_cout", 16'(cout), 16'h0);

    // Single-digit build wraps 9 -> 0
    do_load(12'h009);
    chk("d1_load", 16'(q1), 16'h9);
    pulse(1'b1);
    chk("d1_wrap_q", 16'(q1), 16'h0);
    chk("d1_wrap_cout", 16'(cout1), 16'h1);
    chk("d3_after_009", 16'(q), 16'h010);

    // Asynchronous reset during continuous counting
    do_load(12'h000);
    cin = 1'b1; up_dn = 1'b1;
    repeat (3) tick();
    chk("pre_rst_q", 16'(q), 16'h003);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_q", 16'(q), 16'h000);
    tick();
    chk("rst_hold_q", 16'(q), 16'h000);
    rst = 1'b0;
    tick();
    cin = 1'b0;
    chk("post_rst_q", 16'(q), 16'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_bcd_updown_counter
`default_nettype wire
